// File: rtl/csr_trap_ctrl_if.sv
// Front-end redirect handshake: csr_trap_ctrl drives it as master, fetch answers as slave.
interface csr_trap_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  redirect_valid;
  logic                  redirect_ready;
  logic [DATA_WIDTH-1:0] redirect_pc;

  modport master (
    output redirect_valid,
    output redirect_pc,
    input  redirect_ready
  );

  modport slave (
    input  redirect_valid,
    input  redirect_pc,
    output redirect_ready
  );
endinterface

// File: rtl/csr_trap_ctrl.sv
// Trap/ERTN sequencer and TVAL countdown timer sitting beside the LoongArch CSR bank.
// Define CSR_TIMER_EN to build the TVAL timer and ESTAT.IS[11]; otherwise both read as 0.
module csr_trap_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] crmd,
  input  logic [DATA_WIDTH-1:0] prmd,
  input  logic [DATA_WIDTH-1:0] ecfg,
  input  logic [DATA_WIDTH-1:0] estat,
  input  logic [DATA_WIDTH-1:0] era,
  input  logic [DATA_WIDTH-1:0] eentry,
  input  logic [DATA_WIDTH-1:0] tcfg,
  input  logic                  csr_we,
  input  logic [13:0]           csr_waddr,
  input  logic [DATA_WIDTH-1:0] csr_wdata,
  input  logic                  commit_valid,
  input  logic [DATA_WIDTH-1:0] commit_pc,
  input  logic                  excp_valid,
  input  logic [5:0]            excp_ecode,
  input  logic [8:0]            excp_esubcode,
  input  logic                  excp_badv_valid,
  input  logic [DATA_WIDTH-1:0] excp_badv,
  input  logic                  ertn_valid,
  input  logic [7:0]            hw_int,
  input  logic                  ipi,
  output logic                  busy,
  output logic                  flush,
  output logic                  crmd_we,
  output logic                  prmd_we,
  output logic                  era_we,
  output logic                  estat_we,
  output logic                  badv_we,
  output logic [DATA_WIDTH-1:0] crmd_nxt,
  output logic [DATA_WIDTH-1:0] prmd_nxt,
  output logic [DATA_WIDTH-1:0] era_nxt,
  output logic [DATA_WIDTH-1:0] estat_nxt,
  output logic [DATA_WIDTH-1:0] badv_nxt,
  csr_trap_ctrl_if.master       rdr,
  output logic [DATA_WIDTH-1:0] tval_o,
  output logic                  timer_int
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRAP  = 2'd1,
    REDIR = 2'd2
  } state_t;

  localparam logic [13:0]           TCFG_ADDR  = 14'h041;
  localparam logic [13:0]           TICLR_ADDR = 14'h044;
  localparam logic [DATA_WIDTH-1:0] ZERO_C     = {DATA_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] ONE_C      = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  state_t                state_r;
  logic                  tint_s;
  logic [12:0]           int_vec_s;
  logic                  int_pend_s;
  logic                  excp_take_s;
  logic                  intr_take_s;
  logic                  ertn_take_s;
  logic [5:0]            ecode_s;
  logic [8:0]            esub_s;
  logic [DATA_WIDTH-1:0] estat_nxt_r;
  logic                  unused_s;

  // Event decode: exception beats interrupt beats ERTN; interrupt pending mirrors the ESTAT.IS layout.
  always_comb begin
    int_vec_s   = estat[12:0] | {ipi, tint_s, 1'b0, hw_int, 2'b00};
    int_pend_s  = crmd[2] & (|(int_vec_s & ecfg[12:0]));
    excp_take_s = commit_valid & excp_valid;
    intr_take_s = commit_valid & ~excp_valid & int_pend_s;
    ertn_take_s = commit_valid & ~excp_valid & ~int_pend_s & ertn_valid;
    if (excp_take_s) begin
      ecode_s = excp_ecode;
      esub_s  = excp_esubcode;
    end else begin
      ecode_s = 6'd0;
      esub_s  = 9'd0;
    end
  end

  // Bit 11 is spliced in live so it always shows the current timer interrupt.
  assign estat_nxt = {estat_nxt_r[DATA_WIDTH-1:12], tint_s, estat_nxt_r[10:0]};
  assign timer_int = tint_s;

  // Trap sequencer: sample in IDLE, pulse CSR strobes in TRAP, hold redirect in REDIR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r            <= IDLE;
      busy               <= 1'b0;
      flush              <= 1'b0;
      crmd_we            <= 1'b0;
      prmd_we            <= 1'b0;
      era_we             <= 1'b0;
      estat_we           <= 1'b0;
      badv_we            <= 1'b0;
      crmd_nxt           <= ZERO_C;
      prmd_nxt           <= ZERO_C;
      era_nxt            <= ZERO_C;
      estat_nxt_r        <= ZERO_C;
      badv_nxt           <= ZERO_C;
      rdr.redirect_valid <= 1'b0;
      rdr.redirect_pc    <= ZERO_C;
    end else begin
      case (state_r)
        IDLE: begin
          if (excp_take_s || intr_take_s) begin
            state_r         <= TRAP;
            busy            <= 1'b1;
            flush           <= 1'b1;
            crmd_we         <= 1'b1;
            prmd_we         <= 1'b1;
            era_we          <= 1'b1;
            estat_we        <= 1'b1;
            badv_we         <= excp_take_s & excp_badv_valid;
            crmd_nxt        <= {crmd[DATA_WIDTH-1:3], 3'b000};
            prmd_nxt        <= {prmd[DATA_WIDTH-1:3], crmd[2:0]};
            era_nxt         <= commit_pc;
            estat_nxt_r     <= {estat[31], esub_s, ecode_s, estat[15:0]};
            rdr.redirect_pc <= eentry;
            if (excp_take_s && excp_badv_valid) begin
              badv_nxt <= excp_badv;
            end else begin
              badv_nxt <= badv_nxt;
            end
          end else if (ertn_take_s) begin
            state_r         <= TRAP;
            busy            <= 1'b1;
            flush           <= 1'b1;
            crmd_we         <= 1'b1;
            crmd_nxt        <= {crmd[DATA_WIDTH-1:3], prmd[2:0]};
            rdr.redirect_pc <= era;
          end else begin
            state_r <= IDLE;
          end
        end
        TRAP: begin
          state_r            <= REDIR;
          flush              <= 1'b0;
          crmd_we            <= 1'b0;
          prmd_we            <= 1'b0;
          era_we             <= 1'b0;
          estat_we           <= 1'b0;
          badv_we            <= 1'b0;
          rdr.redirect_valid <= 1'b1;
        end
        REDIR: begin
          if (rdr.redirect_ready) begin
            state_r            <= IDLE;
            busy               <= 1'b0;
            rdr.redirect_valid <= 1'b0;
          end else begin
            state_r <= REDIR;
          end
        end
        default: begin
          state_r            <= IDLE;
          busy               <= 1'b0;
          flush              <= 1'b0;
          crmd_we            <= 1'b0;
          prmd_we            <= 1'b0;
          era_we             <= 1'b0;
          estat_we           <= 1'b0;
          badv_we            <= 1'b0;
          rdr.redirect_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef CSR_TIMER_EN
  logic [DATA_WIDTH-1:0] tval_r;
  logic                  tint_r;
  logic                  tcfg_wr_s;
  logic                  ticlr_s;
  logic                  expire_s;

  assign tcfg_wr_s = csr_we && (csr_waddr == TCFG_ADDR);
  assign ticlr_s   = csr_we && (csr_waddr == TICLR_ADDR) && csr_wdata[0];
  // A TCFG write in the same cycle suppresses the 1->0 step, so it cannot raise the interrupt.
  assign expire_s  = !tcfg_wr_s && tcfg[0] && (tval_r == ONE_C);
  assign tval_o    = tval_r;
  assign tint_s    = tint_r;
  assign unused_s  = ^{csr_wdata[1], ecfg[DATA_WIDTH-1:13]};

  // TVAL countdown with optional periodic reload; timer interrupt set beats TICLR clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tval_r <= ZERO_C;
      tint_r <= 1'b0;
    end else begin
      if (tcfg_wr_s) begin
        if (csr_wdata[0]) begin
          tval_r <= {csr_wdata[DATA_WIDTH-1:2], 2'b00};
        end else begin
          tval_r <= tval_r;
        end
      end else if (tcfg[0] && (tval_r != ZERO_C)) begin
        if (tval_r == ONE_C) begin
          tval_r <= tcfg[1] ? {tcfg[DATA_WIDTH-1:2], 2'b00} : ZERO_C;
        end else begin
          tval_r <= tval_r - ONE_C;
        end
      end else begin
        tval_r <= tval_r;
      end
      if (expire_s) begin
        tint_r <= 1'b1;
      end else if (ticlr_s) begin
        tint_r <= 1'b0;
      end else begin
        tint_r <= tint_r;
      end
    end
  end
`else
  assign tval_o   = ZERO_C;
  assign tint_s   = 1'b0;
  assign unused_s = ^{csr_we, csr_waddr, csr_wdata, tcfg, ecfg[DATA_WIDTH-1:13],
                      TCFG_ADDR, TICLR_ADDR, ONE_C};
`endif

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Self-checking bench for csr_trap_ctrl: directed scenarios plus randomized events vs a reference model.
module tb_csr_trap_ctrl;
`ifdef CSR_TIMER_EN
  localparam bit TIMER_EN = 1'b1;
`else
  localparam bit TIMER_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] crmd, prmd, ecfg, estat, era, eentry, tcfg;
  logic        csr_we;
  logic [13:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic        excp_valid;
  logic [5:0]  excp_ecode;
  logic [8:0]  excp_esubcode;
  logic        excp_badv_valid;
  logic [31:0] excp_badv;
  logic        ertn_valid;
  logic [7:0]  hw_int;
  logic        ipi;
  logic        busy, flush, crmd_we, prmd_we, era_we, estat_we, badv_we;
  logic [31:0] crmd_nxt, prmd_nxt, era_nxt, estat_nxt, badv_nxt, tval_o;
  logic        timer_int;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_tval;
  logic        m_tint;

  csr_trap_ctrl_if #(.DATA_WIDTH(32)) rif ();

  csr_trap_ctrl #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .crmd(crmd), .prmd(prmd), .ecfg(ecfg), .estat(estat), .era(era), .eentry(eentry), .tcfg(tcfg),
    .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .commit_valid(commit_valid), .commit_pc(commit_pc),
    .excp_valid(excp_valid), .excp_ecode(excp_ecode), .excp_esubcode(excp_esubcode),
    .excp_badv_valid(excp_badv_valid), .excp_badv(excp_badv),
    .ertn_valid(ertn_valid), .hw_int(hw_int), .ipi(ipi),
    .busy(busy), .flush(flush),
    .crmd_we(crmd_we), .prmd_we(prmd_we), .era_we(era_we), .estat_we(estat_we), .badv_we(badv_we),
    .crmd_nxt(crmd_nxt), .prmd_nxt(prmd_nxt), .era_nxt(era_nxt), .estat_nxt(estat_nxt),
    .badv_nxt(badv_nxt), .rdr(rif), .tval_o(tval_o), .timer_int(timer_int)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock: advance the timer reference model from the inputs seen at this edge, then compare.
  task automatic tick();
    logic [31:0] n_tval;
    logic        n_tint;
    logic        tw, tc, fire;
    n_tval = m_tval;
    n_tint = m_tint;
    fire   = 1'b0;
    if (TIMER_EN) begin
      tw = csr_we && (csr_waddr == 14'h041);
      tc = csr_we && (csr_waddr == 14'h044) && csr_wdata[0];
      if (tw) begin
        if (csr_wdata[0]) n_tval = csr_wdata & 32'hFFFF_FFFC;
      end else if (tcfg[0] && m_tval != 32'd0) begin
        if (m_tval == 32'd1) begin
          fire   = 1'b1;
          n_tval = tcfg[1] ? (tcfg & 32'hFFFF_FFFC) : 32'd0;
        end else begin
          n_tval = m_tval - 32'd1;
        end
      end
      n_tint = fire ? 1'b1 : (tc ? 1'b0 : m_tint);
    end
    @(posedge clk);
    #1;
    m_tval = n_tval;
    m_tint = n_tint;
    chk("tval_o", tval_o, m_tval);
    chk1("timer_int", timer_int, m_tint);
  endtask

  task automatic idle_inputs();
    commit_valid = 1'b0;
    excp_valid   = 1'b0;
    ertn_valid   = 1'b0;
    csr_we       = 1'b0;
  endtask

  task automatic csr_write(input logic [13:0] a, input logic [31:0] d);
    csr_we    = 1'b1;
    csr_waddr = a;
    csr_wdata = d;
    if (a == 14'h041) tcfg = d;
    tick();
    csr_we = 1'b0;
  endtask

  // Inputs must be ignored outside IDLE, so throw noise at them.
  task automatic scramble();
    commit_valid = 1'b1;
    excp_valid   = ($urandom_range(0, 1) == 1);
    ertn_valid   = ($urandom_range(0, 1) == 1);
    commit_pc    = $urandom;
    crmd         = $urandom;
    prmd         = $urandom;
    ecfg         = $urandom;
    estat        = $urandom;
    era          = $urandom;
    eentry       = $urandom;
    hw_int       = 8'($urandom);
    excp_ecode   = 6'($urandom);
  endtask

  // Drive one commit (inputs already set by caller) through sample, TRAP, REDIR and handshake.
  task automatic run_event(input int ready_delay);
    logic [31:0] pend, e_crmd, e_prmd, e_era, e_estat, e_pc, e_badv;
    logic [4:0]  e_we;
    int          kind;
    pend = ((estat & 32'h0000_1FFF) | (32'(hw_int) << 2) | (32'(ipi) << 12) | (32'(m_tint) << 11))
           & ecfg & 32'h0000_1FFF;
    if (!commit_valid)                 kind = 0;
    else if (excp_valid)               kind = 1;
    else if (crmd[2] && pend != 32'd0) kind = 2;
    else if (ertn_valid)               kind = 3;
    else                               kind = 0;
    e_prmd  = (prmd & ~32'd7) | (crmd & 32'd7);
    e_crmd  = (kind == 3) ? ((crmd & ~32'd7) | (prmd & 32'd7)) : (crmd & ~32'd7);
    e_era   = commit_pc;
    e_estat = estat & ~32'h7FFF_0800;
    if (kind == 1) e_estat = e_estat | (32'(excp_esubcode) << 22) | (32'(excp_ecode) << 16);
    e_pc    = (kind == 3) ? era : eentry;
    e_badv  = excp_badv;
    e_we    = (kind == 3) ? 5'b10000 : {4'b1111, (kind == 1) && excp_badv_valid};
    tick();
    if (kind == 0) begin
      idle_inputs();
      chk1("idle_busy", busy, 1'b0);
      chk1("idle_flush", flush, 1'b0);
      chk("idle_we", {27'd0, crmd_we, prmd_we, era_we, estat_we, badv_we}, 32'd0);
      return;
    end
    scramble();
    chk1("t1_flush", flush, 1'b1);
    chk1("t1_busy", busy, 1'b1);
    chk1("t1_rvalid", rif.redirect_valid, 1'b0);
    chk("t1_we", {27'd0, crmd_we, prmd_we, era_we, estat_we, badv_we}, {27'd0, e_we});
    chk("t1_crmd_nxt", crmd_nxt, e_crmd);
    if (kind != 3) begin
      chk("t1_prmd_nxt", prmd_nxt, e_prmd);
      chk("t1_era_nxt", era_nxt, e_era);
      chk("t1_estat_nxt", estat_nxt, e_estat | (32'(m_tint) << 11));
      if (e_we[0]) chk("t1_badv_nxt", badv_nxt, e_badv);
    end
    tick();
    chk1("t2_flush", flush, 1'b0);
    chk("t2_we", {27'd0, crmd_we, prmd_we, era_we, estat_we, badv_we}, 32'd0);
    chk1("t2_busy", busy, 1'b1);
    chk1("t2_rvalid", rif.redirect_valid, 1'b1);
    chk("t2_rpc", rif.redirect_pc, e_pc);
    for (int i = 0; i < ready_delay; i++) begin
      tick();
      chk1("hold_rvalid", rif.redirect_valid, 1'b1);
      chk("hold_rpc", rif.redirect_pc, e_pc);
    end
    idle_inputs();
    rif.redirect_ready = 1'b1;
    tick();
    rif.redirect_ready = 1'b0;
    chk1("done_busy", busy, 1'b0);
    chk1("done_rvalid", rif.redirect_valid, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    crmd = 32'd0; prmd = 32'd0; ecfg = 32'd0; estat = 32'd0; era = 32'd0; eentry = 32'd0; tcfg = 32'd0;
    csr_waddr = 14'd0; csr_wdata = 32'd0; commit_pc = 32'd0; excp_ecode = 6'd0; excp_esubcode = 9'd0;
    excp_badv_valid = 1'b0; excp_badv = 32'd0; hw_int = 8'd0; ipi = 1'b0;
    rif.redirect_ready = 1'b0;
    idle_inputs();
    m_tval = 32'd0;
    m_tint = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy_flush", {30'd0, busy, flush}, 32'd0);
    chk("rst_we", {27'd0, crmd_we, prmd_we, era_we, estat_we, badv_we}, 32'd0);
    chk("rst_nxt_or", crmd_nxt | prmd_nxt | era_nxt | estat_nxt | badv_nxt, 32'd0);
    chk1("rst_rvalid", rif.redirect_valid, 1'b0);
    chk("rst_rpc", rif.redirect_pc, 32'd0);
    chk("rst_tval", tval_o, 32'd0);
    chk1("rst_tint", timer_int, 1'b0);
    rst_n = 1'b1;
    tick();

    // Exception example
    crmd = 32'h7; prmd = 32'h0; ecfg = 32'h0; estat = 32'h0;
    commit_pc = 32'h1C00_0100; eentry = 32'h1C00_8000;
    commit_valid = 1'b1; excp_valid = 1'b1; excp_ecode = 6'h0B; excp_esubcode = 9'h0;
    excp_badv_valid = 1'b1; excp_badv = 32'hDEAD_BEE0;
    run_event(0);

    // ERTN example
    crmd = 32'h0; prmd = 32'h7; era = 32'h1C00_0200; ecfg = 32'h0; estat = 32'h0;
    commit_valid = 1'b1; ertn_valid = 1'b1;
    run_event(2);

    // One-shot timer: 8 down to 0, interrupt on reaching 0, then TICLR
    csr_write(14'h041, 32'h0000_0009);
    chk("oneshot_load", tval_o, TIMER_EN ? 32'd8 : 32'd0);
    repeat (8) tick();
    chk1("oneshot_int", timer_int, TIMER_EN);
    repeat (3) tick();
    chk("oneshot_stay0", tval_o, 32'd0);
    csr_write(14'h042, 32'h0000_0100);
    csr_write(14'h044, 32'h0000_0001);
    chk1("ticlr_clear", timer_int, 1'b0);

    // Periodic timer with TICLR landing on the expiry cycle
    csr_write(14'h041, 32'h0000_000B);
    repeat (7) tick();
    csr_write(14'h044, 32'h0000_0001);
    chk1("ticlr_on_expiry", timer_int, TIMER_EN);
    chk("periodic_reload", tval_o, TIMER_EN ? 32'd8 : 32'd0);
    repeat (12) tick();
    csr_write(14'h044, 32'h0000_0001);

    // Timer interrupt vs exception
    csr_write(14'h041, 32'h0000_0009);
    repeat (8) tick();
    crmd = 32'h4; prmd = 32'h0; ecfg = 32'h800; estat = 32'h0; hw_int = 8'h0; ipi = 1'b0;
    commit_pc = 32'h1C00_0300; eentry = 32'h1C00_8000;
    commit_valid = 1'b1; excp_valid = 1'b1; excp_ecode = 6'h0B; excp_esubcode = 9'h0;
    excp_badv_valid = 1'b0;
    run_event(0);
    chk("excp_wins_ecode", {26'd0, estat_nxt[21:16]}, 32'h0B);
    crmd = 32'h4; ecfg = 32'h800; estat = 32'h0; hw_int = 8'h0; ipi = 1'b0;
    commit_valid = 1'b1; excp_valid = 1'b0; ertn_valid = 1'b0;
    run_event(1);
`ifdef CSR_TIMER_EN
    chk("int_ecode", {26'd0, estat_nxt[21:16]}, 32'h0);
`endif
    csr_write(14'h044, 32'h0000_0001);

    // Randomized commits with a periodic timer in the background
    csr_write(14'h041, 32'h0000_0013);
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 3) == 0) csr_write(14'h044, 32'h0000_0001);
      crmd            = $urandom;
      prmd            = $urandom;
      ecfg            = ($urandom_range(0, 1) == 1) ? $urandom : 32'd0;
      estat           = ($urandom_range(0, 1) == 1) ? $urandom : ($urandom & 32'hFFFF_E000);
      era             = $urandom;
      eentry          = $urandom;
      commit_pc       = $urandom;
      hw_int          = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'd0;
      ipi             = ($urandom_range(0, 3) == 0);
      commit_valid    = ($urandom_range(0, 7) != 0);
      excp_valid      = ($urandom_range(0, 2) == 0);
      ertn_valid      = ($urandom_range(0, 1) == 1);
      excp_ecode      = 6'($urandom);
      excp_esubcode   = 9'($urandom);
      excp_badv_valid = ($urandom_range(0, 1) == 1);
      excp_badv       = $urandom;
      run_event(int'($urandom_range(0, 3)));
    end

    // Reset while holding a redirect
    crmd = 32'h3; prmd = 32'h0; ecfg = 32'h0; estat = 32'h0;
    commit_pc = 32'h1C00_0400; eentry = 32'h1C00_9000;
    commit_valid = 1'b1; excp_valid = 1'b1; excp_ecode = 6'h08; excp_badv_valid = 1'b0;
    tick();
    idle_inputs();
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk1("rst_hold_rvalid", rif.redirect_valid, 1'b1);
      chk("rst_hold_rpc", rif.redirect_pc, 32'h1C00_9000);
    end
    rst_n = 1'b0;
    #1;
    m_tval = 32'd0;
    m_tint = 1'b0;
    tcfg   = 32'd0;
    chk1("async_rst_rvalid", rif.redirect_valid, 1'b0);
    chk1("async_rst_busy", busy, 1'b0);
    chk("async_rst_tval", tval_o, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    crmd = 32'h0; prmd = 32'h5; era = 32'h1C00_0500; ecfg = 32'h0;
    commit_valid = 1'b1; excp_valid = 1'b0; ertn_valid = 1'b1;
    run_event(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/csr_trap_ctrl.md
# csr_trap_ctrl

Trap and timer sequencer for the LoongArch CSR file. Sits beside the CSR register bank at the commit stage. It owns the TVAL countdown timer and the timer-interrupt bit ESTAT.IS[11]. It arbitrates committed exceptions, pending interrupts and ERTN, then sequences the CSR update and the front-end redirect over a fixed two-phase handshake.

## Interface
- DATA_WIDTH, 32 (from width_param): CSR data and PC width.
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- crmd, prmd, ecfg, estat, era, eentry, tcfg  in  32 each  current CSR values.
- csr_we  in  1  committed CSR write strobe.
- csr_waddr  in  14  CSR write address.
- csr_wdata  in  32  CSR write data, already masked.
- commit_valid  in  1  an instruction commits this cycle.
- commit_pc  in  32  PC of the committing instruction.
- excp_valid  in  1  the committing instruction raised an exception.
- excp_ecode  in  6  exception code.
- excp_esubcode  in  9  exception sub-code.
- excp_badv_valid  in  1  BADV must be written.
- excp_badv  in  32  faulting address.
- ertn_valid  in  1  the committing instruction is ERTN.
- hw_int  in  8  external interrupt lines, level.
- ipi  in  1  inter-processor interrupt, level.
- busy  out  1  state ≠ IDLE; commit must stall.
- flush  out  1  pipeline flush, one cycle.
- crmd_we, prmd_we, era_we, estat_we, badv_we  out  1 each  CSR update strobes.
- crmd_nxt, prmd_nxt, era_nxt, estat_nxt, badv_nxt  out  32 each  update values.
- redirect_valid  out  1  redirect request to fetch.
- redirect_ready  in  1  fetch accepts the redirect.
- redirect_pc  out  32  redirect target.
- tval_o  out  32  live TVAL value.
- timer_int  out  1  sticky timer interrupt (ESTAT.IS[11]).

## Operation
- States are IDLE, TRAP, REDIR.
- IDLE samples events when commit_valid=1. Priority is exception, then interrupt, then ERTN.
- An interrupt is taken when crmd[2]=1 and ((estat[12:0] | {timer_int,1'b0,hw_int,ipi-bit placement per ESTAT.IS}) & ecfg[12:0]) ≠ 0. The interrupt uses ecode 0x0 and era=commit_pc.
- Any event moves IDLE to TRAP. With no event the block stays in IDLE.
- TRAP lasts one cycle and asserts flush and the update strobes:
  - Exception or interrupt: prmd_nxt[2:0]={crmd[2],crmd[1:0]}; crmd_nxt clears PLV and IE; era_nxt=commit_pc; estat_nxt[21:16]=ecode and estat_nxt[30:22]=esubcode; badv is written only when excp_badv_valid=1. redirect_pc=eentry.
  - ERTN: crmd_nxt[2:0]=prmd[2:0]; only crmd_we is asserted. redirect_pc=era.
  - TRAP moves to REDIR.
- REDIR holds redirect_valid=1 and a stable redirect_pc until redirect_ready=1, then returns to IDLE.
- Inputs are ignored in TRAP and REDIR.
- Timer:
  - A CSR write to TCFG (0x41) with wdata[0]=1 loads tval={wdata[31:2],2'b00}. With wdata[0]=0 the timer stops and tval holds.
  - While tcfg[0]=1 and tval≠0, tval decrements by 1 each cycle.
  - On the 1→0 step, timer_int is set. If tcfg[1]=1 (periodic), tval reloads {tcfg[31:2],2'b00} on the same cycle; otherwise it stays 0.
  - Writes to TVAL (0x42) are ignored.
  - A write to TICLR (0x44) with wdata[0]=1 clears timer_int.
  - If timer_int is set and cleared in the same cycle, set wins.
  - A TCFG write and a decrement in the same cycle: the write wins.
- estat_nxt[11] always carries timer_int.

## Timing
- Reset values: state IDLE; all strobes, flush, busy, redirect_valid and timer_int are 0; tval_o=0; redirect_pc=0; all *_nxt outputs are 0.
- An event sampled at cycle T gives TRAP strobes and flush at T+1 and redirect_valid from T+2.
- If redirect_ready=1 at T+2, the block is back in IDLE at T+3 and can accept a new event at T+3.
- busy is high from T+1 through the handshake cycle.
- tval_o is registered and reflects the decrement one cycle after it occurs.
- If rst_n is asserted mid-sequence, the block goes to IDLE immediately, redirect_valid drops and the redirect is abandoned.

## Configuration
- CSR_TIMER_EN:
  - Defined: the timer logic above is built.
  - Undefined: tval_o=0, timer_int=0, TCFG/TICLR writes are ignored and estat_nxt[11]=0. The trap sequencing is unchanged.

## Test plan
- excp_valid with ecode 0x0B, commit_pc 0x1C00_0100, eentry 0x1C00_8000, crmd 0x7 → T+1: era_nxt=0x1C00_0100, crmd_nxt[2:0]=0, prmd_nxt[2:0]=0x7, flush=1; T+2: redirect_pc=0x1C00_8000.
- ERTN with prmd 0x7, era 0x1C00_0200 → crmd_nxt[2:0]=0x7, only crmd_we=1, redirect_pc=0x1C00_0200.
- TCFG write 0x0000_0009 (En=1, periodic=0, init 8) → tval counts 8 down to 0, timer_int=1 on the cycle tval reaches 0, tval stays 0; TICLR write 0x1 clears timer_int.
- TCFG write 0x0000_000B (periodic) → tval reloads to 8 after each expiry and timer_int stays set until cleared; a TICLR issued on the expiry cycle leaves timer_int=1.
- ecfg[11]=1, crmd[2]=1, timer fires while commit_valid=1 together with excp_valid → the exception wins and estat_nxt[21:16]=the exception ecode; with excp_valid=0 the interrupt is taken with ecode 0.
- Hold redirect_ready=0 for 5 cycles, then assert rst_n=0 in REDIR → redirect_valid stays stable over the 5 cycles, then drops immediately with busy=0.
